// File: rtl/shader_pkg.sv
// Shared constants and types for the shader exp/log function-unit arbiter.
package shader_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 64;
    localparam int TMR_W_DEF   = 7;

    localparam logic OP_EXP = 1'b0;
    localparam logic OP_LN  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/shader_rr_pick.sv
// Two-way grant picker: fixed priority (req0 first) or round-robin against last_grant.
module shader_rr_pick (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       mode_fixed,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (mode_fixed) begin
            grant[0] = valid[0];
            grant[1] = valid[1] & ~valid[0];
        end else if (valid == 2'b11) begin
            // On a tie the requester that did not win last time goes next.
            grant[0] = last_grant;
            grant[1] = ~last_grant;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/shader_fu_arbiter.sv
// Shares one iterative exp/ln unit between the colour (req0) and intensity (req1) paths,
// with a completion timeout and result routing back to the issuing requester.
module shader_fu_arbiter
    import shader_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TMR_W   = TMR_W_DEF
) (
    input  logic              clk100,
    input  logic              rst_n,
    input  logic              mode_fixed,
    input  logic              req0_valid,
    input  logic              req0_op,
    input  logic [DATA_W-1:0] req0_arg,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_op,
    input  logic [DATA_W-1:0] req1_arg,
    output logic              req1_ready,
    output logic              fu_start,
    output logic              fu_op,
    output logic [DATA_W-1:0] fu_arg,
    input  logic              fu_done,
    input  logic [DATA_W-1:0] fu_result,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             last_grant;
    logic             owner;
    logic [1:0]       grant;
    logic             idle;

    shader_rr_pick u_pick (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .mode_fixed (mode_fixed),
        .grant      (grant)
    );

    assign idle = (state == ST_IDLE);

    // Gated by rst_n so the strobes stay low while reset is held.
    assign req0_ready = rst_n & idle & grant[0];
    assign req1_ready = rst_n & idle & grant[1];

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            fu_start   <= 1'b0;
            fu_op      <= 1'b0;
            fu_arg     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fu_start   <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant[0]) begin
                        owner    <= 1'b0;
                        fu_op    <= req0_op;
                        fu_arg   <= req0_arg;
                        fu_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end else if (grant[1]) begin
                        owner    <= 1'b1;
                        fu_op    <= req1_op;
                        fu_arg   <= req1_arg;
                        fu_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    // A completion on the final timeout cycle still counts as success.
                    if (fu_done) begin
                        rsp_data   <= fu_result;
                        rsp_err    <= 1'b0;
                        rsp0_valid <= ~owner;
                        rsp1_valid <= owner;
                        state      <= ST_RESP;
                    end else if (timer == TMR_LAST) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        rsp0_valid <= ~owner;
                        rsp1_valid <= owner;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    last_grant <= owner;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/shader_fu_arbiter.md
Name: shader_fu_arbiter

Overview:
- Shares one iterative exp/log function unit (FU) between two pixel-shader requesters: requester 0 is the colour-channel path, requester 1 is the intensity path.
- Sits between the per-pixel shader pipelines and the FU, inside top, on the clk100 domain.
- Arbitrates, issues one operation at a time, watches for FU completion with a timeout, and routes each result back to the requester that issued it.
- sw-driven mode selects round-robin or fixed priority.

Parameters:
- DATA_W, 16, width of FU argument and result (Q8.8).
- TIMEOUT, 64, maximum WAIT cycles before an operation is aborted; must be >= 2.
- TMR_W, 7, timer width; must satisfy 2^TMR_W > TIMEOUT.

Ports:
- clk100  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- mode_fixed  in  1  1 = fixed priority (req0 always wins); 0 = round-robin.
- req0_valid  in  1  requester 0 has an operation.
- req0_op  in  1  0 = exp, 1 = ln.
- req0_arg  in  DATA_W  operand.
- req0_ready  out  1  acceptance strobe for requester 0.
- req1_valid, req1_op, req1_arg, req1_ready: same as requester 0, for requester 1.
- fu_start  out  1  one-cycle start pulse to the FU.
- fu_op  out  1  operation to the FU; held from ISSUE through WAIT.
- fu_arg  out  DATA_W  operand to the FU; held from ISSUE through WAIT.
- fu_done  in  1  FU completion pulse.
- fu_result  in  DATA_W  FU result, valid with fu_done.
- rsp0_valid  out  1  one-cycle response to requester 0.
- rsp1_valid  out  1  one-cycle response to requester 1.
- rsp_data  out  DATA_W  result; shared by both requesters, qualified by rspN_valid.
- rsp_err  out  1  response is a timeout abort.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE, timer 0, last_grant 1, so req0 wins the first tie.
  - All outputs go to 0: req*_ready, fu_start, fu_op, fu_arg, rsp*_valid, rsp_data, rsp_err, busy.
  - Reset mid-operation discards the in-flight op and emits no response.
  - A late fu_done after reset release is ignored.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any reqN_valid, choose a winner.
  - mode_fixed = 1: req0 wins whenever req0_valid.
  - mode_fixed = 0: a lone requester wins; if both are valid, the one not equal to last_grant wins.
  - reqN_ready is combinational: (state == IDLE) and winner == N. It is high for exactly that cycle.
  - Same edge: capture op and arg into fu_op/fu_arg, record owner, go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE: fu_start = 1 for one cycle, clear timer, go to WAIT.
- WAIT:
  - Timer increments every cycle.
  - fu_done = 1: register fu_result into rsp_data, set rsp_err = 0, go to RESP.
  - Timer reaches TIMEOUT-1 without fu_done: set rsp_data = 0, rsp_err = 1, go to RESP.
  - fu_done in the same cycle as the timeout: fu_done wins, rsp_err = 0.
- RESP:
  - rsp{owner}_valid = 1 for one cycle.
  - last_grant <= owner; go to IDLE.
  - There is no response backpressure; requesters must sink the response.
- fu_done outside WAIT is ignored.
- fu_op and fu_arg hold their last value in IDLE and RESP.
- busy = (state != IDLE), registered.
- Latency:
  - Accept at cycle T, fu_start at T+1.
  - fu_done at T+1+k (k >= 1) gives rsp valid at T+2+k.
  - Earliest next accept is T+3+k.
- rsp_data and rsp_err are held until the next response; they are not cleared when the valid pulse ends.
- Changing mode_fixed takes effect at the next IDLE decision only; an in-flight op is unaffected.

Decomposition:
- Package shader_pkg:
  - OP_EXP = 1'b0, OP_LN = 1'b1.
  - State encoding: ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP (2-bit).
  - Default DATA_W and TIMEOUT constants.
- One natural sub-module, shader_rr_pick: a combinational 2-way picker taking valid[1:0], last_grant and mode_fixed and producing grant[1:0].
- The FSM, timer and registers stay in shader_fu_arbiter.
- The testbench needs a behavioural FU model with programmable latency k.

Test Plan:
- Single request: req0 op = 0, arg = 0x0100, FU k = 5, result 0x02B8. Expect req0_ready 1 cycle; fu_start at T+1 with fu_arg = 0x0100, fu_op = 0; rsp0_valid at T+7 with rsp_data = 0x02B8, rsp_err = 0.
- Round-robin, both valid continuously, k = 2. Expect grants 0, 1, 0, 1 in order, each response on the matching rspN_valid; no grant is lost or duplicated.
- Fixed priority: mode_fixed = 1, both valid for 3 ops. Expect req0 granted 3 times and req1_ready never asserted; then drop req0_valid, expect req1 granted next.
- Timeout: FU never asserts done, TIMEOUT = 64. Expect rsp valid 64 cycles after WAIT entry with rsp_data = 0x0000, rsp_err = 1, then IDLE. Second case: fu_done exactly on the timeout cycle gives rsp_err = 0 with the real result.
- Reset mid-WAIT: drop rst_n asynchronously between clock edges. Expect all outputs 0 immediately and no rsp pulse. A stale fu_done pulsed after release is ignored. The next req1-vs-req0 tie grants req0.
- Spurious fu_done in IDLE and ISSUE. Expect no response, no state change, rsp_data unchanged.
